// File: rtl/instruction_memory.sv
// Clocked instruction store for the CPU fetch port: programmable response latency,
// a side preload port, and HALT_WORD returned for indices beyond the array.
`timescale 1ns/1ps

module instruction_memory #(
  parameter int          DEPTH     = 16,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] HALT_WORD = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  output logic [31:0] mem_value,
  output logic        mem_ready,
  input  logic        load_enable,
  input  logic [31:0] load_address,
  input  logic [31:0] load_data,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshake: mem_read is level-held by the requester until it sees mem_ready.
  // A request is accepted on the first edge in IDLE sampling mem_read=1; mem_ready
  // rises LATENCY edges later and stays high while mem_read remains 1. Dropping
  // mem_read while waiting aborts; dropping it in READY ends the transfer.

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  count;
  logic [30:0] req_index;
  logic [31:0] read_word;
  logic        in_range;
  logic        last_edge;
  logic        accept;
  logic        finish;
  logic        addr_bit0_unused;

  // Contents are a power-up image only; reset never touches them.
  logic [31:0] array [DEPTH] = '{default: 32'd0};

  assign addr_bit0_unused = mem_address[0];
  assign last_edge        = (count == 4'd1);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_read) state_next = WAIT;
      WAIT:    if (!mem_read) state_next = IDLE;
               else if (last_edge) state_next = READY;
      READY:   if (!mem_read) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    state_dbg = state;
    accept    = (state == IDLE) && mem_read;
    finish    = (state == WAIT) && mem_read && last_edge;
  end

  // Full-width compare so large indices never alias into the array.
  always_comb begin
    in_range  = ({1'b0, req_index} < 32'(DEPTH));
    read_word = in_range ? array[req_index[AW-1:0]] : HALT_WORD;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= 4'd0;
      req_index <= 31'd0;
      mem_value <= 32'd0;
      mem_ready <= 1'b0;
    end else begin
      if (accept) begin
        req_index <= mem_address[31:1];
        count     <= LAT_CNT;
      end
      if (state == WAIT) begin
        if (!mem_read)      count <= 4'd0;
        else if (finish)    count <= 4'd0;
        else                count <= count - 4'd1;
      end
      if (finish) begin
        mem_value <= read_word;
        mem_ready <= 1'b1;
      end
      if ((state == READY) && !mem_read) mem_ready <= 1'b0;
    end
  end

  // Separate write process: a load on the sampling edge is seen only afterwards.
  always_ff @(posedge clock) begin
    if (load_enable && (load_address < 32'(DEPTH)))
      array[load_address[AW-1:0]] <= load_data;
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Bench for instruction_memory: two instances (latency 2 and 4) on shared stimulus,
// a directed vector table, corner-case sequences, a fetch loop and random traffic.
`timescale 1ns/1ps

module tb_instruction_memory;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_address = 32'd0;
  logic        mem_read = 1'b0;
  logic        load_enable = 1'b0;
  logic [31:0] load_address = 32'd0;
  logic [31:0] load_data = 32'd0;

  logic [31:0] value_a, value_b;
  logic        ready_a, ready_b, busy_a, busy_b;
  logic [1:0]  state_a, state_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  instruction_memory #(.DEPTH(16), .LATENCY(2), .HALT_WORD(32'd1)) dut_a (
    .clock(clock), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
    .mem_value(value_a), .mem_ready(ready_a), .load_enable(load_enable),
    .load_address(load_address), .load_data(load_data), .busy(busy_a), .state_dbg(state_a)
  );

  instruction_memory #(.DEPTH(16), .LATENCY(4), .HALT_WORD(32'd1)) dut_b (
    .clock(clock), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
    .mem_value(value_b), .mem_ready(ready_b), .load_enable(load_enable),
    .load_address(load_address), .load_data(load_data), .busy(busy_b), .state_dbg(state_b)
  );

  // Reference: each instance is either idle, waiting with an edge count since
  // acceptance, or presenting a response. Memory is a plain array.
  logic [31:0] m_mem [16];
  bit          m_pend [2];
  int          m_age [2];
  logic [30:0] m_idx [2];
  logic        m_ready [2];
  logic [31:0] m_value [2];
  int          lat [2] = '{2, 4};

  function automatic logic [31:0] ref_read(input logic [30:0] idx);
    if (idx < 31'd16) return m_mem[idx[3:0]];
    return 32'd1;
  endfunction

  task automatic model_step(input logic rst, input logic rd, input logic [31:0] addr,
                            input logic le, input logic [31:0] la, input logic [31:0] ld);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pend[i] = 0; m_ready[i] = 1'b0; m_value[i] = 32'd0;
      end else if (m_pend[i]) begin
        if (!rd) m_pend[i] = 0;
        else begin
          m_age[i]++;
          if (m_age[i] == lat[i]) begin
            m_ready[i] = 1'b1;
            m_value[i] = ref_read(m_idx[i]);
            m_pend[i]  = 0;
          end
        end
      end else if (m_ready[i]) begin
        if (!rd) m_ready[i] = 1'b0;
      end else if (rd) begin
        m_pend[i] = 1; m_age[i] = 0; m_idx[i] = addr[31:1];
      end
    end
    if (le && la < 32'd16) m_mem[la[3:0]] = ld;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("lat2_ready", {31'd0, ready_a}, {31'd0, m_ready[0]});
    check("lat2_value", value_a, m_value[0]);
    check("lat2_busy", {31'd0, busy_a}, {31'd0, m_pend[0] || m_ready[0]});
    check("lat4_ready", {31'd0, ready_b}, {31'd0, m_ready[1]});
    check("lat4_value", value_b, m_value[1]);
    check("lat4_busy", {31'd0, busy_b}, {31'd0, m_pend[1] || m_ready[1]});
  endtask

  task automatic cycle(input logic rst, input logic rd, input logic [31:0] addr,
                       input logic le, input logic [31:0] la, input logic [31:0] ld);
    reset = rst; mem_read = rd; mem_address = addr;
    load_enable = le; load_address = la; load_data = ld;
    @(posedge clock);
    model_step(rst, rd, addr, le, la, ld);
    #1;
    check_model();
  endtask

  task automatic rd_cycle(input logic rd, input logic [31:0] addr);
    cycle(1'b0, rd, addr, 1'b0, 32'd0, 32'd0);
  endtask

  typedef struct {
    logic        rst;
    logic        rd;
    logic [31:0] addr;
    logic        le;
    logic [31:0] la;
    logic [31:0] ld;
    logic        exp_ready;
    logic [31:0] exp_value;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int pulses;
    int halt_pc;
    bit halted;
    bit got;
    logic rd;
    logic [31:0] addr;

    foreach (m_mem[i]) m_mem[i] = 32'd0;
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_age[i] = 0; m_idx[i] = '0; m_ready[i] = 1'b0; m_value[i] = 32'd0;
    end

    // Expected columns refer to the latency-2 instance.
    vecs.push_back('{1, 0, 0,  0, 0,  0,            0, 32'h0});
    vecs.push_back('{0, 0, 0,  1, 3,  0,            0, 32'h0});
    vecs.push_back('{0, 0, 0,  1, 1,  32'hA,        0, 32'h0});
    vecs.push_back('{0, 0, 0,  1, 15, 32'h12345678, 0, 32'h0});
    vecs.push_back('{0, 0, 0,  1, 16, 32'hDEAD,     0, 32'h0});
    vecs.push_back('{0, 1, 6,  0, 0,  0,            0, 32'h0});
    vecs.push_back('{0, 1, 6,  0, 0,  0,            0, 32'h0});
    vecs.push_back('{0, 1, 6,  0, 0,  0,            1, 32'h0});
    vecs.push_back('{0, 1, 6,  0, 0,  0,            1, 32'h0});
    vecs.push_back('{0, 0, 6,  0, 0,  0,            0, 32'h0});
    vecs.push_back('{0, 1, 34, 0, 0,  0,            0, 32'h0});
    vecs.push_back('{0, 1, 0,  0, 0,  0,            0, 32'h0});
    vecs.push_back('{0, 1, 0,  0, 0,  0,            1, 32'h1});
    vecs.push_back('{0, 0, 0,  0, 0,  0,            0, 32'h1});
    vecs.push_back('{0, 1, 32, 0, 0,  0,            0, 32'h1});
    vecs.push_back('{0, 1, 32, 0, 0,  0,            0, 32'h1});
    vecs.push_back('{0, 1, 32, 0, 0,  0,            1, 32'h1});
    vecs.push_back('{0, 0, 32, 0, 0,  0,            0, 32'h1});
    vecs.push_back('{0, 1, 30, 0, 0,  0,            0, 32'h1});
    vecs.push_back('{0, 1, 30, 0, 0,  0,            0, 32'h1});
    vecs.push_back('{0, 1, 30, 0, 0,  0,            1, 32'h12345678});
    vecs.push_back('{0, 0, 30, 0, 0,  0,            0, 32'h12345678});
    vecs.push_back('{0, 1, 3,  0, 0,  0,            0, 32'h12345678});
    vecs.push_back('{0, 1, 3,  0, 0,  0,            0, 32'h12345678});
    vecs.push_back('{0, 1, 3,  0, 0,  0,            1, 32'hA});
    vecs.push_back('{0, 0, 3,  0, 0,  0,            0, 32'hA});

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].rd, vecs[i].addr, vecs[i].le, vecs[i].la, vecs[i].ld);
      check($sformatf("vec%0d_ready", i), {31'd0, ready_a}, {31'd0, vecs[i].exp_ready});
      check($sformatf("vec%0d_value", i), value_a, vecs[i].exp_value);
    end

    // Abort on the latency-4 instance, then a clean request.
    rd_cycle(1'b0, 32'd0);
    rd_cycle(1'b1, 32'd8);
    rd_cycle(1'b1, 32'd8);
    check("abort_wait_ready", {31'd0, ready_b}, 32'd0);
    rd_cycle(1'b0, 32'd8);
    check("abort_busy", {31'd0, busy_b}, 32'd0);
    check("abort_ready", {31'd0, ready_b}, 32'd0);
    rd_cycle(1'b1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      rd_cycle(1'b1, 32'd2);
      check("abort_retry_early", {31'd0, ready_b}, 32'd0);
    end
    rd_cycle(1'b1, 32'd2);
    check("abort_retry_ready", {31'd0, ready_b}, 32'd1);
    check("abort_retry_value", value_b, 32'hA);
    rd_cycle(1'b0, 32'd2);

    // Load on the sampling edge returns old data.
    rd_cycle(1'b1, 32'd2);
    rd_cycle(1'b1, 32'd2);
    cycle(1'b0, 1'b1, 32'd2, 1'b1, 32'd1, 32'hB);
    check("coll_same_ready", {31'd0, ready_a}, 32'd1);
    check("coll_same_value", value_a, 32'hA);
    rd_cycle(1'b1, 32'd2);
    rd_cycle(1'b1, 32'd2);
    rd_cycle(1'b0, 32'd2);
    // Load one edge earlier is visible.
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'd1, 32'hA);
    rd_cycle(1'b1, 32'd2);
    cycle(1'b0, 1'b1, 32'd2, 1'b1, 32'd1, 32'hB);
    rd_cycle(1'b1, 32'd2);
    check("coll_early_ready", {31'd0, ready_a}, 32'd1);
    check("coll_early_value", value_a, 32'hB);
    rd_cycle(1'b1, 32'd2);
    rd_cycle(1'b1, 32'd2);
    rd_cycle(1'b0, 32'd2);

    // Reset while presenting a response; array survives.
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'd5, 32'h55);
    rd_cycle(1'b1, 32'd10);
    rd_cycle(1'b1, 32'd10);
    rd_cycle(1'b1, 32'd10);
    check("rst_pre_value", value_a, 32'h55);
    cycle(1'b1, 1'b1, 32'd10, 1'b0, 32'd0, 32'd0);
    check("rst_ready", {31'd0, ready_a}, 32'd0);
    check("rst_value", value_a, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    rd_cycle(1'b0, 32'd10);
    rd_cycle(1'b1, 32'd10);
    rd_cycle(1'b1, 32'd10);
    rd_cycle(1'b1, 32'd10);
    check("rst_reread_value", value_a, 32'h55);
    rd_cycle(1'b0, 32'd10);

    // Fetch loop as the CPU would run it: NOOPs then HALT at word 9.
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    for (int w = 0; w < 10; w++)
      cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'(w), (w == 9) ? 32'd1 : 32'd0);
    pc = 0; pulses = 0; halted = 0; halt_pc = -1;
    for (int f = 0; f < 12 && !halted; f++) begin
      exp_q.push_back((pc / 2 == 9) ? 32'd1 : 32'd0);
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        rd_cycle(1'b1, 32'(pc));
        got = ready_a;
      end
      if (!got) begin
        check("fetch_timeout", {31'd0, ready_a}, 32'd1);
        break;
      end
      pulses++;
      check($sformatf("fetch_value_pc%0d", pc), value_a, exp_q.pop_front());
      if (value_a == 32'd1) begin
        halted = 1; halt_pc = pc;
      end
      rd_cycle(1'b0, 32'(pc));
      pc += 2;
    end
    check("fetch_halt_pc", 32'(halt_pc), 32'd18);
    check("fetch_pulses", 32'(pulses), 32'd10);

    // Random traffic against the reference.
    rd = 1'b0; addr = 32'd0;
    for (int c = 0; c < 2000; c++) begin
      logic rst, le;
      logic [31:0] la, ld;
      if (rd) begin
        if ($urandom_range(0, 5) == 0) rd = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        rd = 1'b1;
      end
      if ($urandom_range(0, 4) == 0)
        addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      rst = ($urandom_range(0, 59) == 0);
      le  = ($urandom_range(0, 4) == 0);
      la  = 32'($urandom_range(0, 20));
      ld  = $urandom;
      cycle(rst, rd, addr, le, la, ld);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
# instruction_memory

Synchronous, single-port instruction store that serves the CPU core's fetch handshake (`mem_address`/`mem_read` in, `mem_value`/`mem_ready` out). It replaces the behavioural memory emulator in the CPU bench with a clocked block that has a programmable response latency, a side load port for preloading programs, and a defined out-of-range response. It sits directly downstream of the CPU fetch stage, and its response feeds the CPU's opcode register.

## Interface

- `DEPTH`, 16: number of 32-bit instruction words stored.
- `LATENCY`, 2: clock edges from request acceptance to `mem_ready` high. Legal range is 1..15.
- `HALT_WORD`, 1: value returned for addresses beyond the array (the HALT opcode).

- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_address`  in  32  byte address of the fetch; word index is `mem_address[31:1]`, and bit 0 is ignored.
- `mem_read`  in  1  fetch request, level-held by the CPU until it sees `mem_ready`.
- `mem_value`  out  32  fetched instruction word; valid while `mem_ready` is high.
- `mem_ready`  out  1  response valid.
- `load_enable`  in  1  write strobe for the preload port.
- `load_address`  in  32  word index (not byte address) for the preload write.
- `load_data`  in  32  word to write.
- `busy`  out  1  high in WAIT and READY.

## Operation

- **State machine:** IDLE, WAIT, READY.
- **IDLE:**
  - When an edge samples `mem_read`=1, latch `mem_address[31:1]` into the request index.
  - Load the latency counter.
  - Go to WAIT.
- **WAIT:**
  - Count down.
  - On the edge that completes `LATENCY` edges since acceptance, drive `mem_value` and set `mem_ready`=1, then go to READY.
  - If any edge in WAIT samples `mem_read`=0, abort: go to IDLE, and `mem_ready` never rises.
- **READY:**
  - Hold `mem_value` and `mem_ready`=1 stable while `mem_read`=1.
  - On the first edge sampling `mem_read`=0, set `mem_ready`=0, go to IDLE, and leave `mem_value` holding its last value.
- **Read data:**
  - If the index is less than `DEPTH`, return `array[index]`.
  - Otherwise return `HALT_WORD`.
  - The comparison is on the full 31-bit index, so there is no wrap or truncation.
- **Latching:** `mem_address` changes after acceptance are ignored; the latched index is used.
- **Load port:**
  - Accepted in any state: `array[load_address] <= load_data` when `load_enable`=1 and `load_address` < `DEPTH`.
  - Out-of-range loads are dropped silently.
- **Load/read collision:**
  - Array data is sampled on the WAIT-to-READY edge.
  - A load to the same word on an earlier edge is visible in the response.
  - A load on that same edge returns the old data (read-before-write).
- **Array contents:** initialised to 0 (NOOP) at time zero and not affected by `reset`.
- **Reset:**
  - `reset`=1 at any edge forces IDLE, `mem_ready`=0, `mem_value`=0, `busy`=0, and clears the counter.
  - It overrides any request or response in flight.
  - An active `load_enable` on a reset edge is still performed.

## Timing

- A request accepted at edge k gives `mem_ready` high after edge k+`LATENCY`. With the default, that is 2 cycles.
- **Minimum cycle per fetch:**
  - `LATENCY`+1 edges from acceptance to `mem_ready` low, given the CPU drops `mem_read` in the cycle after `mem_ready` rises.
  - The next request can be accepted no earlier than the edge after `mem_ready` falls (IDLE must be re-entered).
- `mem_read` must be held continuously; a single-cycle drop in WAIT aborts the request.
- `mem_ready` changes only on `clock` edges and never combinationally from `mem_read`.
- `busy` follows the registered state: it is 1 from edge k to the edge where READY exits.

## Test plan

- **Default latency fetch:**
  - Stimulus: reset, preload word 3 = 0x0000_0000; assert `mem_read` with `mem_address`=6 at edge 0.
  - Response: `mem_ready`=1 after edge 2 with `mem_value`=0; `mem_ready`=0 one edge after `mem_read` drops.
- **Out-of-range fetch:**
  - Stimulus: `mem_address`=34 (index 17) with `DEPTH`=16.
  - Response: `mem_value`=1 (`HALT_WORD`); an address of 32 returns `array[16]`, which is also out of range and therefore 1; an address of 30 returns `array[15]`.
- **Abort:**
  - Stimulus: with `LATENCY`=4, drop `mem_read` at edge 2 after acceptance.
  - Response: `mem_ready` stays 0 and the state returns to IDLE; a new request with `mem_address`=2 completes normally 4 edges later.
- **Load collision:**
  - Stimulus: preload word 1 = 0xA; start a read of address 2; load word 1 = 0xB on the WAIT-to-READY edge.
  - Response: `mem_value`=0xA. Repeat with the load one edge earlier: `mem_value`=0xB.
- **Reset mid-operation:**
  - Stimulus: assert `reset` in READY.
  - Response: `mem_ready`=0 and `mem_value`=0 on that edge; array contents preserved (a re-read returns the preloaded value).
- **CPU integration:**
  - Stimulus: connect to the CPU core with words 0..8 = NOOP and word 9 = 1.
  - Response: the CPU fetches addresses 0, 2, …, 18 in order and halts at address 18 (word 9); exactly 10 `mem_ready` pulses are observed.
